epl_ecc_encoder: RTL

Serial systematic encoder for the shortened BCH(15,5,t=3) code used on EPLFFRAM02 words. It sits directly upstream of the ECC decoder on the write path. It takes a 4-bit data word, maps it to the 5-bit payload {1'b0, data}, and computes the 10 parity bits with a bit-serial LFSR over generator g(x) = x^10+x^8+x^5+x^4+x^2+x+1. It presents the 15-bit codeword that the array stores and the decoder later reads back.

---
 rtl/epl_ecc_encoder_pkg.sv | 27 ++
 rtl/epl_ecc_encoder_if.sv | 31 +++
 rtl/epl_ecc_encoder_lfsr_step.sv | 16 +
 rtl/epl_ecc_encoder.sv | 104 ++++++++++
 4 files changed

// File: rtl/epl_ecc_encoder_pkg.sv
// Shared constants and types for the EPLFFRAM02 BCH(15,5,t=3) write-path encoder.
// Payload is {1'b0, data}; the top payload bit is the shortened-away position.
package epl_ecc_encoder_pkg;

    localparam int WORD_WIDTH        = 4;
    localparam int TWORD_WIDTH       = 15;
    localparam int BCH_PARITY_WIDTH  = 10;
    localparam int BCH_PAYLOAD_WIDTH = 5;

    // g(x) = x^10+x^8+x^5+x^4+x^2+x+1; the LFSR only needs the terms below x^10
    localparam logic [BCH_PARITY_WIDTH:0]   BCH_GEN_POLY = 11'h537;
    localparam logic [BCH_PARITY_WIDTH-1:0] GEN_POLY_LO  = BCH_GEN_POLY[BCH_PARITY_WIDTH-1:0];

    localparam logic [2:0] LAST_SHIFT = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } enc_state_t;

    function automatic logic [BCH_PAYLOAD_WIDTH-1:0] make_payload(
        input logic [WORD_WIDTH-1:0] data
    );
        return {1'b0, data};
    endfunction

endpackage

// File: rtl/epl_ecc_encoder_if.sv
// Request/result bundle between a write-path client and the BCH encoder.
// The client owns write/data; the encoder owns busy, codeword, valid and drop.
interface epl_ecc_encoder_if;
    import epl_ecc_encoder_pkg::*;

    logic                   pWRITE_i;
    logic [WORD_WIDTH-1:0]  pDATA_i;
    logic                   pBUSY_o;
    logic [TWORD_WIDTH-1:0] pPARITYDATA_o;
    logic                   pVALID_o;
    logic                   pDROP_o;

    modport master (
        output pWRITE_i,
        output pDATA_i,
        input  pBUSY_o,
        input  pPARITYDATA_o,
        input  pVALID_o,
        input  pDROP_o
    );

    modport slave (
        input  pWRITE_i,
        input  pDATA_i,
        output pBUSY_o,
        output pPARITYDATA_o,
        output pVALID_o,
        output pDROP_o
    );

endinterface

// File: rtl/epl_ecc_encoder_lfsr_step.sv
// One bit-serial step of the parity LFSR over g(x): feed one message bit, MSB first.
// After the last payload bit the register holds m(x)*x^10 mod g(x).
module epl_bch_lfsr_step
    import epl_ecc_encoder_pkg::*;
(
    input  logic [BCH_PARITY_WIDTH-1:0] lfsr_in,
    input  logic                        bit_in,
    output logic [BCH_PARITY_WIDTH-1:0] lfsr_out
);

    logic feedback;

    assign feedback = bit_in ^ lfsr_in[BCH_PARITY_WIDTH-1];
    assign lfsr_out = {lfsr_in[BCH_PARITY_WIDTH-2:0], 1'b0} ^ (feedback ? GEN_POLY_LO : '0);

endmodule

// File: rtl/epl_ecc_encoder.sv
// Serial systematic BCH(15,5) encoder: accepts a 4-bit word, shifts its 5-bit payload
// through the parity LFSR over five clocks, then presents {payload, parity} with a valid pulse.
module epl_ecc_encoder
    import epl_ecc_encoder_pkg::*;
(
    input  logic                    pCLK_i,
    input  logic                    pRST_i,
    epl_ecc_encoder_if.slave        bus
);

    enc_state_t                   state_r,    state_next;
    logic [2:0]                   cnt_r,      cnt_next;
    logic [BCH_PAYLOAD_WIDTH-1:0] msg_r,      msg_next;
    logic [BCH_PARITY_WIDTH-1:0]  lfsr_r,     lfsr_next;
    logic [TWORD_WIDTH-1:0]       codeword_r, codeword_next;
    logic                         valid_r,    valid_next;
    logic                         drop_r,     drop_next;

    logic                         cnt_legal;
    logic [2:0]                   bit_idx;
    logic                         msg_bit;
    logic [BCH_PARITY_WIDTH-1:0]  lfsr_shifted;

    // Payload is consumed MSB first; an out-of-range count feeds a harmless zero
    assign cnt_legal = (cnt_r <= LAST_SHIFT);
    assign bit_idx   = LAST_SHIFT - cnt_r;
    assign msg_bit   = cnt_legal ? msg_r[bit_idx] : 1'b0;

    epl_bch_lfsr_step u_lfsr_step (
        .lfsr_in  (lfsr_r),
        .bit_in   (msg_bit),
        .lfsr_out (lfsr_shifted)
    );

    always_comb begin
        state_next    = state_r;
        cnt_next      = cnt_r;
        msg_next      = msg_r;
        lfsr_next     = lfsr_r;
        codeword_next = codeword_r;
        valid_next    = 1'b0;
        drop_next     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.pWRITE_i) begin
                    msg_next   = make_payload(bus.pDATA_i);
                    lfsr_next  = '0;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // A request arriving mid-encode is rejected; the word in flight continues
                drop_next = bus.pWRITE_i;
                if (!cnt_legal) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (cnt_r == LAST_SHIFT) begin
                    lfsr_next     = lfsr_shifted;
                    cnt_next      = '0;
                    codeword_next = {msg_r, lfsr_shifted};
                    valid_next    = 1'b1;
                    state_next    = ST_IDLE;
                end else begin
                    lfsr_next = lfsr_shifted;
                    cnt_next  = cnt_r + 3'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Reset wins over any request and discards a partially built codeword
    always_ff @(posedge pCLK_i) begin
        if (pRST_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            msg_r      <= '0;
            lfsr_r     <= '0;
            codeword_r <= '0;
            valid_r    <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            cnt_r      <= cnt_next;
            msg_r      <= msg_next;
            lfsr_r     <= lfsr_next;
            codeword_r <= codeword_next;
            valid_r    <= valid_next;
            drop_r     <= drop_next;
        end
    end

    assign bus.pBUSY_o       = (state_r != ST_IDLE);
    assign bus.pPARITYDATA_o = codeword_r;
    assign bus.pVALID_o      = valid_r;
    assign bus.pDROP_o       = drop_r;

endmodule
